// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_arbiter slice: FSM encoding, widths
// and a small one-hot helper.
package calc_pkg;

  localparam int W_DEF  = 4;
  localparam int MODO_W = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// Request/response handshake bundle between two requesters and calc_arbiter.
// master = requester side, slave = arbiter side.
interface calc_arbiter_if #(
  parameter int W = calc_pkg::W_DEF
);
  import calc_pkg::*;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*W-1:0]      req_a;
  logic [2*W-1:0]      req_b;
  logic [2*MODO_W-1:0] req_modo;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [W-1:0]        resp_c;

  modport master (
    output req_valid, req_a, req_b, req_modo, resp_ready,
    input  req_ready, resp_valid, resp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, req_modo, resp_ready,
    output req_ready, resp_valid, resp_c
  );

endinterface

// File: rtl/calc_arbiter_rr_arb2.sv
// Combinational two-way picker: a lone requester wins outright, a tie goes to
// the requester named by ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_onehot,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    gnt_idx    = 1'b0;
    gnt_onehot = 2'b00;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = 1'b0;
    endcase
    if (req != 2'b00) gnt_onehot = gnt_idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared calculadora datapath.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = 1          // calculadora latency, legal 1..15
) (
  input  logic              clk,
  input  logic              rst,
  calc_arbiter_if.slave     bus,
  output logic [W-1:0]      calc_a,
  output logic [W-1:0]      calc_b,
  output logic [MODO_W-1:0] calc_modo,
  input  logic [W-1:0]      calc_c,
  output logic              busy
);

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             gnt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win_onehot;
  logic             win_idx;
  logic             accept;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx)
  );

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = win_onehot;
        accept        = |(bus.req_valid & win_onehot);
        if (accept) state_nxt = WAIT;
      end
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        bus.resp_valid = onehot2(gnt);
        if (bus.resp_ready[gnt]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: all state is sequential and uses non-blocking assignments; reset
  // clears every register so outputs are 0 and in-flight work is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      cnt        <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      calc_modo  <= '0;
      bus.resp_c <= '0;
    end else begin
      state <= state_nxt;
      // calc_* only change on accept, so they hold through WAIT/RESP/IDLE.
      if (accept) begin
        calc_a    <= win_idx ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
        calc_b    <= win_idx ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
        calc_modo <= win_idx ? bus.req_modo[2*MODO_W-1:MODO_W]
                             : bus.req_modo[MODO_W-1:0];
        gnt       <= win_idx;
        cnt       <= CNT_W'(LAT);
      end
      if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           bus.resp_c <= calc_c;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  // Tie-break pointer moves to the other requester after each completed response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= 1'b0;
    else if (state == RESP && bus.resp_ready[gnt])
      rr_ptr <= ~gnt;
  end
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: LAT=1 instance for most scenarios and a
// LAT=3 instance for the longer-latency case, both against a calculadora stub.
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int W    = 4;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pref        = 0;   // model: who wins a tie next

  logic [3:0] pa [2];
  logic [3:0] pb [2];
  logic [1:0] pm [2];

  calc_arbiter_if #(.W(W)) bus1 ();
  calc_arbiter_if #(.W(W)) bus3 ();

  logic [W-1:0] calc_a1, calc_b1, calc_c1, calc_a3, calc_b3, calc_c3;
  logic [1:0]   calc_modo1, calc_modo3;
  logic         busy1, busy3;

  calc_arbiter #(.W(W), .LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .calc_a(calc_a1), .calc_b(calc_b1), .calc_modo(calc_modo1),
    .calc_c(calc_c1), .busy(busy1)
  );

  calc_arbiter #(.W(W), .LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .calc_a(calc_a3), .calc_b(calc_b3), .calc_modo(calc_modo3),
    .calc_c(calc_c3), .busy(busy3)
  );

  // calculadora stub: add / subtract / and / or, LAT register stages
  function automatic logic [3:0] stub_fn(input logic [3:0] a, b, input logic [1:0] m);
    case (m)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  logic [3:0] pipe1 [LAT1];
  logic [3:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe1[0] <= stub_fn(calc_a1, calc_b1, calc_modo1);
    for (int i = 1; i < LAT1; i++) pipe1[i] <= pipe1[i-1];
    pipe3[0] <= stub_fn(calc_a3, calc_b3, calc_modo3);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign calc_c1 = pipe1[LAT1-1];
  assign calc_c3 = pipe3[LAT3-1];

  // Reference model
  function automatic int model_winner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return pref;
`endif
  endfunction

  function automatic int model_result(input int a, b, m);
    case (m)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.req_modo = '0;
    bus1.resp_ready = 2'b00;
    bus3.req_valid = 2'b00; bus3.req_a = '0; bus3.req_b = '0; bus3.req_modo = '0;
    bus3.resp_ready = 2'b00;
  endtask

  task automatic reset_dut();
    idle_all();
    rst = 1'b0;
    step();
    step();
    rst  = 1'b1;
    pref = 0;
  endtask

  // One full transaction on bus1 with LAT1; leaves the bench in the first IDLE cycle.
  task automatic transact(input logic [1:0] v, input int bp);
    int         w, exp_c;
    logic [1:0] exp_oh;
    w      = model_winner(v);
    exp_oh = (w == 1) ? 2'b10 : 2'b01;
    exp_c  = model_result(int'(pa[w]), int'(pb[w]), int'(pm[w]));
    bus1.req_valid  = v;
    bus1.req_a      = {pa[1], pa[0]};
    bus1.req_b      = {pb[1], pb[0]};
    bus1.req_modo   = {pm[1], pm[0]};
    bus1.resp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (bus1.req_ready !== exp_oh) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b expected %b", bus1.req_ready, exp_oh);
    end
    step();
    for (int i = 0; i <= LAT1; i++) begin
      if (i > 0) step();
      bus1.req_valid = 2'($urandom);
      #1;
      vectors++;
      if ({busy1, bus1.resp_valid, bus1.req_ready} !== {1'b1, 2'b00, 2'b00}) begin
        miscompares++;
        $display("FAIL wait_ctl: got busy=%b resp_valid=%b req_ready=%b expected 1/00/00",
                 busy1, bus1.resp_valid, bus1.req_ready);
      end
      vectors++;
      if ({calc_a1, calc_b1, calc_modo1} !== {pa[w], pb[w], pm[w]}) begin
        miscompares++;
        $display("FAIL calc_ops: got a=%h b=%h m=%h expected a=%h b=%h m=%h",
                 calc_a1, calc_b1, calc_modo1, pa[w], pb[w], pm[w]);
      end
    end
    step();
    for (int j = 0; j <= bp; j++) begin
      if (j > 0) step();
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.req_ready, busy1} !== {exp_oh, 2'b00, 1'b1}) begin
        miscompares++;
        $display("FAIL resp_valid: got %b (req_ready=%b busy=%b) expected %b",
                 bus1.resp_valid, bus1.req_ready, busy1, exp_oh);
      end
      vectors++;
      if (bus1.resp_c !== 4'(exp_c)) begin
        miscompares++;
        $display("FAIL resp_c: got %0d expected %0d", bus1.resp_c, exp_c);
      end
      bus1.resp_ready = (j < bp) ? ~exp_oh : exp_oh;
      bus1.req_valid  = 2'($urandom);
    end
    step();
    bus1.req_valid  = 2'b00;
    bus1.resp_ready = 2'b00;
    #1;
    vectors++;
    if ({bus1.resp_valid, busy1} !== {2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL resp_done: got resp_valid=%b busy=%b expected 00/0", bus1.resp_valid, busy1);
    end
    pref = 1 - w;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    step();
    vectors++;
    if ({busy1, bus1.resp_valid, bus1.resp_c, calc_a1, calc_b1, calc_modo1, busy3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b rv=%b c=%h a=%h b=%h m=%h expected all 0",
               busy1, bus1.resp_valid, bus1.resp_c, calc_a1, calc_b1, calc_modo1);
    end
    rst = 1'b1; pref = 0;
    pa[0] = 4'd3; pb[0] = 4'd4; pm[0] = 2'd0;
    bus1.req_a = {4'd0, pa[0]}; bus1.req_b = {4'd0, pb[0]}; bus1.req_modo = 4'd0;
    bus1.req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (bus1.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_accept: got req_ready=%b expected 01", bus1.req_ready);
    end
    step();
    bus1.req_valid = 2'b00;
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy1, bus1.resp_valid, bus1.resp_c, calc_a1, calc_b1, calc_modo1} !== '0) begin
      miscompares++;
      $display("FAIL reset_midwait: got busy=%b rv=%b c=%h a=%h b=%h m=%h expected all 0",
               busy1, bus1.resp_valid, bus1.resp_c, calc_a1, calc_b1, calc_modo1);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if ({bus1.resp_valid, busy1} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_no_resp: got resp_valid=%b busy=%b expected 00/0", bus1.resp_valid, busy1);
      end
    end
  endtask

  task automatic test_single();
    reset_dut();
    pa[0] = 4'd3; pb[0] = 4'd4; pm[0] = 2'd0;
    pa[1] = 4'd0; pb[1] = 4'd0; pm[1] = 2'd0;
    transact(2'b01, 0);
    pa[1] = 4'd6; pb[1] = 4'd9; pm[1] = 2'd1;
    transact(2'b10, 0);
  endtask

  task automatic test_simultaneous();
    reset_dut();
    pa[0] = 4'd9; pb[0] = 4'd8; pm[0] = 2'd0;
    pa[1] = 4'd2; pb[1] = 4'd5; pm[1] = 2'd1;
    for (int i = 0; i < 4; i++) transact(2'b11, 0);
  endtask

  task automatic test_backpressure();
    reset_dut();
    pa[0] = 4'd12; pb[0] = 4'd7; pm[0] = 2'd1;
    transact(2'b01, 5);
    pa[1] = 4'd10; pb[1] = 4'd6; pm[1] = 2'd2;
    transact(2'b10, 3);
  endtask

  task automatic test_random();
    int gap;
    reset_dut();
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        pa[r] = 4'($urandom); pb[r] = 4'($urandom); pm[r] = 2'($urandom);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        vectors++;
        if ({bus1.req_ready, busy1} !== 3'b000) begin
          miscompares++;
          $display("FAIL idle_gap: got req_ready=%b busy=%b expected 00/0", bus1.req_ready, busy1);
        end
      end
      transact(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_lat3();
    int exp_c;
    reset_dut();
    exp_c = model_result(15, 1, 0);
    bus3.req_a = {4'd0, 4'd15}; bus3.req_b = {4'd0, 4'd1}; bus3.req_modo = 4'd0;
    bus3.req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (bus3.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL lat3_accept: got req_ready=%b expected 01", bus3.req_ready);
    end
    step();
    bus3.req_valid = 2'b00;
    for (int i = 0; i <= LAT3; i++) begin
      if (i > 0) step();
      #1;
      vectors++;
      if ({bus3.resp_valid, busy3} !== {2'b00, 1'b1}) begin
        miscompares++;
        $display("FAIL lat3_wait: cycle T+%0d got resp_valid=%b busy=%b expected 00/1",
                 i + 1, bus3.resp_valid, busy3);
      end
    end
    step();
    vectors++;
    if ({bus3.resp_valid, bus3.resp_c} !== {2'b01, 4'(exp_c)}) begin
      miscompares++;
      $display("FAIL lat3_resp: got resp_valid=%b resp_c=%0d expected 01/%0d",
               bus3.resp_valid, bus3.resp_c, exp_c);
    end
    bus3.resp_ready = 2'b01;
    step();
    bus3.resp_ready = 2'b00;
    vectors++;
    if ({bus3.resp_valid, busy3} !== 3'b000) begin
      miscompares++;
      $display("FAIL lat3_done: got resp_valid=%b busy=%b expected 00/0", bus3.resp_valid, busy3);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_random();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
